spi_mem_loader: RTL and testbench

- Parametrised successor to the processor's serial load path (chip-select FSM plus 12-bit shift buffer), split out as a standalone slave.
- Serially receives {rw, addr, data} frames on mosi_i under one of NUM_CH active-low chip selects.
- Drives a one-cycle write strobe into the selected memory (icache, dcache, frame counter bank, ...).
- Also supports read-back on miso_o, with frame-length checking; the current path has neither.

---
 rtl/spi_mem_loader.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_spi_mem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_loader
// Purpose  : Serial memory loader slave. Receives {rw, addr, data} frames
//            LSB first on mosi_i under one of NUM_CH active-low chip selects,
//            issues a one-cycle write strobe to the selected memory, or reads
//            a word back out on miso_o. Incomplete frames, surplus bits and
//            chip-select conflicts raise a sticky frame_err_o.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          system clock, serial bits sampled on rising edge
//   rst          asynchronous active-high reset
//   cs_n_i       per-channel chip select, active low
//   mosi_i       serial data in, LSB first
//   bit_vld_i    qualifies mosi_i sampling and miso_o advance
//   miso_o       serial read data, LSB first
//   mem_we_o     one-hot, one-cycle write strobe
//   mem_addr_o   target address (shared)
//   mem_wdata_o  write data (shared)
//   mem_rdata_i  combinational read data, channel k at [k*DATA_W +: DATA_W]
//   busy_o       high whenever the FSM is not idle
//   frame_err_o  sticky error; cleared by rst or an all-cs_n-high bit_vld_i
// ----------------------------------------------------------------------------
// Build option:
//   SPI_LOADER_AUTO_INC_EN - when defined, a held chip select after a
//   completed word streams further words at successive addresses.
//   The master leaves one idle cycle after each header and after each read
//   word (RLOAD capture cycle); bits presented in that cycle are ignored.
// ============================================================================
module spi_mem_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        cs_n_i,
    input  logic                     mosi_i,
    input  logic                     bit_vld_i,
    output logic                     miso_o,
    output logic [NUM_CH-1:0]        mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic [NUM_CH*DATA_W-1:0] mem_rdata_i,
    output logic                     busy_o,
    output logic                     frame_err_o
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_DATA   = 3'd2,
        S_WR     = 3'd3,
        S_RLOAD  = 3'd4,
        S_RSHIFT = 3'd5,
        S_WAIT   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  sreg_q,  sreg_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [CH_W-1:0]     ch_q,    ch_d;
    logic                miso_q,  miso_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q,   err_d;
`ifdef SPI_LOADER_AUTO_INC_EN
    // Set once a read word has been streamed; lets cs_n rise cleanly
    // between words instead of counting as an aborted frame.
    logic                stream_q, stream_d;
    logic                burst_go;
    localparam logic [CNT_W-1:0] BURST_START = CNT_W'(ADDR_W + 2);
`endif

    logic [NUM_CH-1:0]   cs_low;
    logic                cs_any;
    logic                cs_multi;
    logic [CH_W-1:0]     cs_idx;
    logic                cs_act;
    logic [FRAME_W-1:0]  shift_in;
    logic [DATA_W-1:0]   rdata_sel;
    logic [CNT_W-1:0]    cnt_inc;

    assign cs_low    = ~cs_n_i;
    assign cs_any    = |cs_low;
    // x & (x-1) clears the lowest set bit; non-zero means two or more lows.
    assign cs_multi  = |(cs_low & (cs_low - NUM_CH'(1)));
    assign cs_act    = ~cs_n_i[ch_q];
    // Frame bits enter at the MSB so a complete frame ends up as {data, addr, rw}.
    assign shift_in  = {mosi_i, sreg_q[FRAME_W-1:1]};
    assign rdata_sel = mem_rdata_i[int'(ch_q)*DATA_W +: DATA_W];
    assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        cs_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cs_low[k]) begin
                cs_idx = CH_W'(k);
            end
        end
    end

`ifdef SPI_LOADER_AUTO_INC_EN
    assign burst_go = bit_vld_i & cs_act & ((state_q == S_WR) | (state_q == S_WAIT));
`endif

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        miso_d   = miso_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
`ifdef SPI_LOADER_AUTO_INC_EN
        stream_d = stream_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef SPI_LOADER_AUTO_INC_EN
                stream_d = 1'b0;
`endif
                if (cs_multi) begin
                    err_d = 1'b1;
                end else if (cs_any) begin
                    ch_d    = cs_idx;
                    state_d = S_HDR;
                    cnt_d   = '0;
                    // A bit presented together with the falling cs_n is kept.
                    if (bit_vld_i) begin
                        sreg_d = shift_in;
                        cnt_d  = CNT_W'(1);
                    end
                end else if (bit_vld_i) begin
                    err_d = 1'b0;
                end
            end
            S_HDR: begin
                if (!cs_act) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (bit_vld_i) begin
                    sreg_d = shift_in;
                    cnt_d  = cnt_inc;
                    if (cnt_q == HDR_LAST) begin
                        addr_d  = shift_in[FRAME_W-1 -: ADDR_W];
                        state_d = shift_in[DATA_W] ? S_RLOAD : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!cs_act) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (bit_vld_i) begin
                    sreg_d = shift_in;
                    cnt_d  = cnt_inc;
                    if (cnt_q == DATA_LAST) begin
                        wdata_d = shift_in[FRAME_W-1 -: DATA_W];
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                // The strobe is already committed; a rising cs_n only
                // decides where we go afterwards.
                if (!cs_act) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
`ifdef SPI_LOADER_AUTO_INC_EN
                    addr_d  = addr_q + ADDR_W'(1);
`else
                    if (bit_vld_i) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            S_RLOAD: begin
                if (!cs_act) begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
`ifdef SPI_LOADER_AUTO_INC_EN
                    err_d   = err_q | ~stream_q;
`else
                    err_d   = 1'b1;
`endif
                end else begin
                    sreg_d  = {{(FRAME_W-DATA_W){1'b0}}, rdata_sel};
                    miso_d  = rdata_sel[0];
                    cnt_d   = '0;
                    state_d = S_RSHIFT;
                end
            end
            S_RSHIFT: begin
                if (!cs_act) begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
`ifdef SPI_LOADER_AUTO_INC_EN
                    err_d   = err_q | ~(stream_q && (cnt_q == '0));
`else
                    err_d   = 1'b1;
`endif
                end else if (bit_vld_i) begin
                    if (cnt_q == RD_LAST) begin
                        miso_d   = 1'b0;
`ifdef SPI_LOADER_AUTO_INC_EN
                        addr_d   = addr_q + ADDR_W'(1);
                        stream_d = 1'b1;
                        state_d  = S_RLOAD;
`else
                        state_d  = S_WAIT;
`endif
                    end else begin
                        sreg_d = sreg_q >> 1;
                        miso_d = sreg_q[1];
                        cnt_d  = cnt_inc;
                    end
                end
            end
            S_WAIT: begin
                if (!cs_act) begin
                    state_d = S_IDLE;
                end else if (bit_vld_i) begin
`ifndef SPI_LOADER_AUTO_INC_EN
                    err_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef SPI_LOADER_AUTO_INC_EN
        // First bit of a follow-on write burst; the counter is preset so the
        // burst ends after DATA_W bits exactly like the data phase of a frame.
        if (burst_go) begin
            sreg_d = shift_in;
            if (DATA_W == 1) begin
                wdata_d = shift_in[FRAME_W-1 -: DATA_W];
                state_d = S_WR;
            end else begin
                cnt_d   = BURST_START;
                state_d = S_DATA;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            ch_q     <= '0;
            miso_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef SPI_LOADER_AUTO_INC_EN
            stream_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            miso_q   <= miso_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
`ifdef SPI_LOADER_AUTO_INC_EN
            stream_q <= stream_d;
`endif
        end
    end

    always_comb begin
        mem_we_o = '0;
        if (state_q == S_WR) begin
            mem_we_o[ch_q] = 1'b1;
        end
    end

    assign miso_o      = miso_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign frame_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mem_loader
// Purpose  : Directed self-checking bench for spi_mem_loader (DATA_W=8,
//            ADDR_W=4, NUM_CH=2). Expected writes go into a scoreboard queue
//            when a frame is driven and are popped when mem_we_o fires.
//            Honours SPI_LOADER_AUTO_INC_EN for the streaming scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cs_n;
    logic        mosi;
    logic        vld;
    logic        miso;
    logic [1:0]  we;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        ferr;

    logic [7:0]  mem0 [16];
    logic [7:0]  mem1 [16];

    typedef struct packed {
        logic [1:0] we;
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    assign rdata = {mem1[addr], mem0[addr]};

    spi_mem_loader #(.DATA_W(8), .ADDR_W(4), .NUM_CH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n_i     (cs_n),
        .mosi_i     (mosi),
        .bit_vld_i  (vld),
        .miso_o     (miso),
        .mem_we_o   (we),
        .mem_addr_o (addr),
        .mem_wdata_o(wdata),
        .mem_rdata_i(rdata),
        .busy_o     (busy),
        .frame_err_o(ferr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, step past the edge, and retire any write
    // strobe against the scoreboard.
    task automatic cyc(input logic [1:0] c, input logic v, input logic d);
        wr_t e;
        cs_n = c;
        vld  = v;
        mosi = d;
        @(posedge clk);
        #1;
        if (we !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", {30'd0, we}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_we",    {30'd0, we},    {30'd0, e.we});
                chk("sb_addr",  {28'd0, addr},  {28'd0, e.addr});
                chk("sb_wdata", {24'd0, wdata}, {24'd0, e.data});
            end
        end
    endtask

    function automatic logic [12:0] frame(input logic rw, input logic [3:0] a, input logic [7:0] d);
        return {d, a, rw};
    endfunction

    task automatic send_bits(input logic [1:0] c, input logic [12:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(c, 1'b1, f[i]);
        end
    endtask

    initial begin
        logic [12:0] f;
        logic [7:0]  rexp;

        for (int i = 0; i < 16; i++) begin
            mem0[i] = 8'(i * 17 + 3);
            mem1[i] = 8'(i * 29 + 7);
        end
        mem0[9] = 8'h3C;

        // ---------------- reset ----------------
        rst = 1'b1; cs_n = 2'b11; vld = 1'b0; mosi = 1'b0;
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_err",   {31'd0, ferr}, 32'd0);
        chk("rst_we",    {30'd0, we},   32'd0);
        chk("rst_miso",  {31'd0, miso}, 32'd0);
        chk("rst_addr",  {28'd0, addr}, 32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'd0);
        rst = 1'b0;
        cyc(2'b11, 1'b0, 1'b0);

        // ---------------- write ch1: addr 5 <- A3 ----------------
        cyc(2'b01, 1'b0, 1'b0);
        sb.push_back('{2'b10, 4'h5, 8'hA3});
        send_bits(2'b01, frame(1'b0, 4'h5, 8'hA3), 13);
        chk("wr1_we_n1", {30'd0, we}, 32'h2);
        chk("wr1_busy",  {31'd0, busy}, 32'd1);
        cyc(2'b01, 1'b0, 1'b0);
        chk("wr1_we_one_cycle", {30'd0, we}, 32'd0);
        cyc(2'b11, 1'b0, 1'b0);
        chk("wr1_busy_fall", {31'd0, busy}, 32'd0);
        chk("wr1_err", {31'd0, ferr}, 32'd0);

        // ---------------- read ch0: addr 9 -> 0x3C ----------------
        cyc(2'b10, 1'b0, 1'b0);
        send_bits(2'b10, frame(1'b1, 4'h9, 8'h00), 5);
        chk("rd_addr", {28'd0, addr}, 32'h9);
        cyc(2'b10, 1'b0, 1'b0);
        rexp = mem0[9];
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rd_miso_%0d", i), {31'd0, miso}, {31'd0, rexp[i]});
            cyc(2'b10, 1'b1, 1'b0);
        end
        chk("rd_miso_idle", {31'd0, miso}, 32'd0);
        cyc(2'b11, 1'b0, 1'b0);
        chk("rd_busy", {31'd0, busy}, 32'd0);
        chk("rd_err",  {31'd0, ferr}, 32'd0);

        // ---------------- abort after 7 write bits ----------------
        cyc(2'b10, 1'b0, 1'b0);
        send_bits(2'b10, frame(1'b0, 4'h3, 8'hFF), 7);
        cyc(2'b11, 1'b0, 1'b0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_err",  {31'd0, ferr}, 32'd1);
        cyc(2'b11, 1'b1, 1'b0);
        chk("abort_clear", {31'd0, ferr}, 32'd0);

        // ---------------- chip-select conflict ----------------
        cyc(2'b00, 1'b0, 1'b0);
        chk("conf_busy", {31'd0, busy}, 32'd0);
        chk("conf_err",  {31'd0, ferr}, 32'd1);
        cyc(2'b11, 1'b0, 1'b0);
        chk("conf_sticky", {31'd0, ferr}, 32'd1);
        cyc(2'b11, 1'b1, 1'b0);
        chk("conf_clear", {31'd0, ferr}, 32'd0);

        // ------- gapped write ch0 addr 2 <- 0F, cs and first bit together,
        // ------- with ch1 briefly selected mid-frame (must be ignored) -------
        sb.push_back('{2'b01, 4'h2, 8'h0F});
        f = frame(1'b0, 4'h2, 8'h0F);
        for (int i = 0; i < 13; i++) begin
            cyc((i >= 6 && i < 9) ? 2'b00 : 2'b10, 1'b1, f[i]);
            if (i == 12) chk("gap_we", {30'd0, we}, 32'h1);
            cyc((i >= 6 && i < 9) ? 2'b00 : 2'b10, 1'b0, 1'b0);
        end
        cyc(2'b11, 1'b0, 1'b0);
        chk("gap_err", {31'd0, ferr}, 32'd0);

        // ---------------- async reset mid-DATA ----------------
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 1'b0);
        send_bits(2'b01, frame(1'b0, 4'h6, 8'h77), 9);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy",  {31'd0, busy},  32'd0);
        chk("arst_err",   {31'd0, ferr},  32'd0);
        chk("arst_addr",  {28'd0, addr},  32'd0);
        chk("arst_wdata", {24'd0, wdata}, 32'd0);
        chk("arst_we",    {30'd0, we},    32'd0);
        chk("arst_miso",  {31'd0, miso},  32'd0);
        cyc(2'b11, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(2'b11, 1'b0, 1'b0);
        sb.push_back('{2'b01, 4'hA, 8'h55});
        cyc(2'b10, 1'b0, 1'b0);
        send_bits(2'b10, frame(1'b0, 4'hA, 8'h55), 13);
        chk("post_rst_we", {30'd0, we}, 32'h1);
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);

`ifdef SPI_LOADER_AUTO_INC_EN
        // ---------------- auto-increment burst across the wrap ----------------
        sb.push_back('{2'b10, 4'hF, 8'h11});
        cyc(2'b01, 1'b0, 1'b0);
        send_bits(2'b01, frame(1'b0, 4'hF, 8'h11), 13);
        chk("ai_first_addr", {28'd0, addr}, 32'hF);
        cyc(2'b01, 1'b0, 1'b0);
        sb.push_back('{2'b10, 4'h0, 8'h22});
        f = {5'd0, 8'h22};
        send_bits(2'b01, f, 8);
        chk("ai_burst_we", {30'd0, we}, 32'h2);
        cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        chk("ai_err",  {31'd0, ferr}, 32'd0);
        chk("ai_busy", {31'd0, busy}, 32'd0);
`else
        // ---------------- surplus bit in WAIT ----------------
        sb.push_back('{2'b10, 4'h1, 8'h5A});
        cyc(2'b01, 1'b0, 1'b0);
        send_bits(2'b01, frame(1'b0, 4'h1, 8'h5A), 13);
        cyc(2'b01, 1'b0, 1'b0);
        chk("extra_pre_err", {31'd0, ferr}, 32'd0);
        cyc(2'b01, 1'b1, 1'b1);
        chk("extra_err", {31'd0, ferr}, 32'd1);
        chk("extra_no_we", {30'd0, we}, 32'd0);
        cyc(2'b11, 1'b0, 1'b0);
        chk("extra_busy", {31'd0, busy}, 32'd0);
        cyc(2'b11, 1'b1, 1'b0);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
